load_store_unit: RTL and testbench
==================================

# load_store_unit

Two-lane load/store execution unit on the consumer side of the dispatch stage's load-store outputs. It accepts up to two memory operations per dispatch cycle (lane A and lane B), serialises them onto a single 16-bit memory request/acknowledge port (A first), returns load data as register write-backs, and back-pressures dispatch with `stall_o` while busy. A flush abandons all captured and in-flight work.

## Interface
- `LOAD_OP`, 7'h20: opcode value that selects a load.
- `STORE_OP`, 7'h21: opcode value that selects a store.
- `TIMEOUT`, 16: cycles a request may wait for `memAck_i` before it is aborted; range 1..255.
- `clock_i` in 1: single clock, rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `flushBack_i` in 1: pipeline flush, synchronous; takes priority over everything except reset.
- `lsEnableA_i`, `lsEnableB_i` in 1: lane has a valid memory operation.
- `isWbLSA_i`, `isWbLSB_i` in 1: a load on this lane writes its result back.
- `lsWbAddressA_i`, `lsWbAddressB_i` in 5: destination register for a load.
- `lsOpCodeA_i`, `lsOpCodeB_i` in 7: operation opcode.
- `lsPoperandA_i`, `lsPoperandB_i` in 16: memory address.
- `lsSoperandA_i`, `lsSoperandB_i` in 16: store data.
- `memAck_i` in 1: memory completes the current request on this edge.
- `memRData_i` in 16: load data, valid on an edge where `memAck_i`=1.
- `memReq_o` out 1: memory request.
- `memWe_o` out 1: 1 = store, 0 = load.
- `memAddr_o`, `memWData_o` out 16: request address and store data.
- `stall_o` out 1: unit is busy; lane inputs are ignored.
- `wbEnable_o` out 1: one-cycle write-back strobe.
- `wbAddress_o` out 5, `wbData_o` out 16: write-back destination and value.
- `lsError_o` out 1: one-cycle pulse on an illegal opcode or a timeout.

## Operation
- States: IDLE, ACC_A, ACC_B. `stall_o` = (state != IDLE). It is driven from the state register, so it is registered.
- In IDLE, both lanes are sampled every edge. If either `lsEnable*_i`=1, the unit captures both lanes' fields and enable bits.
  - Next state is ACC_A if lane A is enabled, otherwise ACC_B.
- Opcode check is done at capture time, per lane. An enabled lane whose opcode is neither LOAD_OP nor STORE_OP is dropped and pulses `lsError_o` on the next cycle.
  - If both lanes are illegal, `lsError_o` pulses for one cycle only.
  - If every enabled lane is illegal, the unit stays in IDLE.
- In ACC_x: `memReq_o`=1, with `memWe_o`, `memAddr_o` (=Poperand) and `memWData_o` (=Soperand, 0 for loads) held stable until the ack.
- On an edge with `memAck_i`=1:
  - Load with isWb=1: `wbAddress_o`/`wbData_o` take the lane address and `memRData_i`, and `wbEnable_o`=1 for the following cycle only.
  - Load with isWb=0, or a store: no write-back.
  - Next state: from ACC_A, ACC_B if lane B is captured and legal, otherwise IDLE. From ACC_B, IDLE.
- A timeout counter resets on entry to each ACC state. When it reaches TIMEOUT with no ack, the access is aborted: `lsError_o` pulses and the unit advances exactly as on an ack, but with no write-back.
- If both lanes load the same register, B's write-back is later and wins.
- Flush: next state is IDLE, captured lanes are cleared, and `memReq_o`=0 from the next cycle. An in-flight store is abandoned; memory must tolerate a request being withdrawn. No `wbEnable_o` or `lsError_o` is generated by the flushed work. `memAck_i` on the flush edge is ignored.
- Reset values: state IDLE, and all outputs 0 (`memReq_o`, `memWe_o`, `memAddr_o`, `memWData_o`, `stall_o`, `wbEnable_o`, `wbAddress_o`, `wbData_o`, `lsError_o`). The timeout counter is 0.

## Timing
- All outputs are registered.
- Accept at edge N: `stall_o`=1 and `memReq_o`=1 from cycle N+1.
- Ack at edge M (earliest M = N+1):
  - Load write-back strobe is high during cycle M..M+1.
  - Single-lane op: `stall_o`=0 from M. A new accept is possible at edge M+1.
  - Dual-lane op: lane B `memReq_o` is high from M with no gap, overlapping lane A's write-back strobe.
- Minimum occupancy: 1 cycle per access with an immediate ack. Single-lane throughput is one operation per 2 cycles.
- Timeout: ack absent for TIMEOUT consecutive request cycles, so the abort happens at edge N+TIMEOUT.
- Upstream must hold its lane outputs while `stall_o`=1.

## Test plan
- Single load: A = load, addr 16'h0040, isWb=1, wb=5; ack one cycle after the request with data 16'hBEEF. Required: `memWe_o`=0, `memAddr_o`=16'h0040, then one cycle of `wbEnable_o` with `wbAddress_o`=5, `wbData_o`=16'hBEEF; `stall_o` high for exactly 1 cycle.
- Dual op: A = store 16'h1234 to 16'h0010, B = load from 16'h0010 to r7; ack each after 2 cycles. Required: the store request precedes the load with no gap, a single write-back to r7 with the ack data, and `stall_o` high for 4 cycles.
- Illegal opcode: A opcode 7'h05 with B disabled. Required: `lsError_o` pulses one cycle, with no `memReq_o` and no `stall_o`.
- Timeout: with TIMEOUT=16, a load is never acked. Required: `memReq_o` high for 16 cycles, then `lsError_o` pulse, no write-back, and a return to IDLE.
- Flush mid-access: flush during lane A's request with lane B pending, and ack the same edge. Required: `memReq_o`=0 next cycle, no B request, no write-back, and `stall_o`=0.
- Reset mid-dual-op: every output is 0 on the cycle after the reset edge, and a fresh load then completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
// Two-lane load/store execution unit. Captures up to two memory operations
// (lane A, lane B) from dispatch, serialises them onto one 16-bit memory
// request/ack port (A first), returns load data as a register write-back and
// stalls dispatch while busy. A flush abandons all captured and in-flight work.
//
// Ports:
//   clock_i, reset_i          clock, synchronous active-high reset
//   flushBack_i               pipeline flush (priority below reset only)
//   lsEnable*_i, isWbLS*_i    lane valid, load writes back
//   lsWbAddress*_i            load destination register
//   lsOpCode*_i               opcode (LOAD_OP / STORE_OP, anything else illegal)
//   lsPoperand*_i             memory address
//   lsSoperand*_i             store data
//   memAck_i, memRData_i      memory completion and load data
//   memReq_o, memWe_o         request strobe, 1 = store
//   memAddr_o, memWData_o     request address and store data
//   stall_o                   unit busy, lane inputs ignored
//   wbEnable_o, wbAddress_o,
//   wbData_o                  one-cycle write-back
//   lsError_o                 one-cycle pulse on illegal opcode or timeout
module load_store_unit #(
  parameter logic [6:0]  LOAD_OP  = 7'h20,
  parameter logic [6:0]  STORE_OP = 7'h21,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        flushBack_i,
  input  logic        lsEnableA_i,
  input  logic        lsEnableB_i,
  input  logic        isWbLSA_i,
  input  logic        isWbLSB_i,
  input  logic [4:0]  lsWbAddressA_i,
  input  logic [4:0]  lsWbAddressB_i,
  input  logic [6:0]  lsOpCodeA_i,
  input  logic [6:0]  lsOpCodeB_i,
  input  logic [15:0] lsPoperandA_i,
  input  logic [15:0] lsPoperandB_i,
  input  logic [15:0] lsSoperandA_i,
  input  logic [15:0] lsSoperandB_i,
  input  logic        memAck_i,
  input  logic [15:0] memRData_i,
  output logic        memReq_o,
  output logic        memWe_o,
  output logic [15:0] memAddr_o,
  output logic [15:0] memWData_o,
  output logic        stall_o,
  output logic        wbEnable_o,
  output logic [4:0]  wbAddress_o,
  output logic [15:0] wbData_o,
  output logic        lsError_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC_A = 2'd1, ACC_B = 2'd2} state_t;

  // Abort fires on the edge where the counter has already seen TIMEOUT-1
  // unacknowledged edges, i.e. after TIMEOUT request cycles.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        b_vld_q, b_vld_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        err_q, err_d;

  // Captured lane payload (no reset needed, qualified by state / b_vld_q)
  logic        a_wb_q, a_wb_d;
  logic [4:0]  a_wb_addr_q, a_wb_addr_d;
  logic        b_we_q, b_we_d;
  logic        b_wb_q, b_wb_d;
  logic [4:0]  b_wb_addr_q, b_wb_addr_d;
  logic [15:0] b_addr_q, b_addr_d;
  logic [15:0] b_wdata_q, b_wdata_d;

  logic a_load, a_store, a_ok, a_bad;
  logic b_load, b_store, b_ok, b_bad;
  logic tmo_hit, cur_wb;
  logic [4:0] cur_wb_addr;

  assign a_load  = (lsOpCodeA_i == LOAD_OP);
  assign a_store = (lsOpCodeA_i == STORE_OP);
  assign a_ok    = lsEnableA_i & (a_load | a_store);
  assign a_bad   = lsEnableA_i & ~(a_load | a_store);
  assign b_load  = (lsOpCodeB_i == LOAD_OP);
  assign b_store = (lsOpCodeB_i == STORE_OP);
  assign b_ok    = lsEnableB_i & (b_load | b_store);
  assign b_bad   = lsEnableB_i & ~(b_load | b_store);

  assign tmo_hit     = (tmo_cnt_q == TMO_LAST);
  assign cur_wb      = (state_q == ACC_A) ? a_wb_q : b_wb_q;
  assign cur_wb_addr = (state_q == ACC_A) ? a_wb_addr_q : b_wb_addr_q;

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    b_vld_d     = b_vld_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;
    a_wb_d      = a_wb_q;
    a_wb_addr_d = a_wb_addr_q;
    b_we_d      = b_we_q;
    b_wb_d      = b_wb_q;
    b_wb_addr_d = b_wb_addr_q;
    b_addr_d    = b_addr_q;
    b_wdata_d   = b_wdata_q;

    if (flushBack_i) begin
      // Flushed work leaves no trace: no ack, write-back or error is taken.
      state_d     = IDLE;
      tmo_cnt_d   = 8'd0;
      b_vld_d     = 1'b0;
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = 16'h0;
      mem_wdata_d = 16'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lsEnableA_i | lsEnableB_i) begin
            err_d       = a_bad | b_bad;
            tmo_cnt_d   = 8'd0;
            a_wb_d      = isWbLSA_i & a_load;
            a_wb_addr_d = lsWbAddressA_i;
            b_we_d      = b_store;
            b_wb_d      = isWbLSB_i & b_load;
            b_wb_addr_d = lsWbAddressB_i;
            b_addr_d    = lsPoperandB_i;
            b_wdata_d   = b_store ? lsSoperandB_i : 16'h0;
            // b_vld marks B still pending behind A.
            b_vld_d     = a_ok & b_ok;
            if (a_ok) begin
              state_d     = ACC_A;
              mem_req_d   = 1'b1;
              mem_we_d    = a_store;
              mem_addr_d  = lsPoperandA_i;
              mem_wdata_d = a_store ? lsSoperandA_i : 16'h0;
            end else if (b_ok) begin
              state_d     = ACC_B;
              mem_req_d   = 1'b1;
              mem_we_d    = b_store;
              mem_addr_d  = lsPoperandB_i;
              mem_wdata_d = b_store ? lsSoperandB_i : 16'h0;
            end
          end
        end
        ACC_A, ACC_B: begin
          if (memAck_i) begin
            if (cur_wb) begin
              wb_en_d   = 1'b1;
              wb_addr_d = cur_wb_addr;
              wb_data_d = memRData_i;
            end
          end else if (tmo_hit) begin
            err_d = 1'b1;
          end
          if (memAck_i | tmo_hit) begin
            tmo_cnt_d = 8'd0;
            if ((state_q == ACC_A) && b_vld_q) begin
              // Back-to-back: B request follows A with no idle cycle.
              state_d     = ACC_B;
              b_vld_d     = 1'b0;
              mem_req_d   = 1'b1;
              mem_we_d    = b_we_q;
              mem_addr_d  = b_addr_q;
              mem_wdata_d = b_wdata_q;
            end else begin
              state_d     = IDLE;
              b_vld_d     = 1'b0;
              mem_req_d   = 1'b0;
              mem_we_d    = 1'b0;
              mem_addr_d  = 16'h0;
              mem_wdata_d = 16'h0;
            end
          end else begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      tmo_cnt_q   <= 8'd0;
      b_vld_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0;
      mem_wdata_q <= 16'h0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= 5'd0;
      wb_data_q   <= 16'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      b_vld_q     <= b_vld_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clock_i) begin
    a_wb_q      <= a_wb_d;
    a_wb_addr_q <= a_wb_addr_d;
    b_we_q      <= b_we_d;
    b_wb_q      <= b_wb_d;
    b_wb_addr_q <= b_wb_addr_d;
    b_addr_q    <= b_addr_d;
    b_wdata_q   <= b_wdata_d;
  end

  assign memReq_o    = mem_req_q;
  assign memWe_o     = mem_we_q;
  assign memAddr_o   = mem_addr_q;
  assign memWData_o  = mem_wdata_q;
  assign stall_o     = (state_q != IDLE);
  assign wbEnable_o  = wb_en_q;
  assign wbAddress_o = wb_addr_q;
  assign wbData_o    = wb_data_q;
  assign lsError_o   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios followed by randomized
// bundles checked against a transaction-level reference model.
module tb_load_store_unit;

  localparam logic [6:0] LOAD_OP  = 7'h20;
  localparam logic [6:0] STORE_OP = 7'h21;
  localparam int         TIMEOUT  = 16;
  localparam int         TMO_DEL  = 255;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        flushBack_i = 1'b0;
  logic        lsEnableA_i = 1'b0, lsEnableB_i = 1'b0;
  logic        isWbLSA_i = 1'b0, isWbLSB_i = 1'b0;
  logic [4:0]  lsWbAddressA_i = '0, lsWbAddressB_i = '0;
  logic [6:0]  lsOpCodeA_i = '0, lsOpCodeB_i = '0;
  logic [15:0] lsPoperandA_i = '0, lsPoperandB_i = '0;
  logic [15:0] lsSoperandA_i = '0, lsSoperandB_i = '0;
  logic        memAck_i = 1'b0;
  logic [15:0] memRData_i = '0;
  logic        memReq_o, memWe_o, stall_o, wbEnable_o, lsError_o;
  logic [15:0] memAddr_o, memWData_o, wbData_o;
  logic [4:0]  wbAddress_o;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit #(.LOAD_OP(LOAD_OP), .STORE_OP(STORE_OP), .TIMEOUT(TIMEOUT)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .flushBack_i(flushBack_i),
    .lsEnableA_i(lsEnableA_i), .lsEnableB_i(lsEnableB_i),
    .isWbLSA_i(isWbLSA_i), .isWbLSB_i(isWbLSB_i),
    .lsWbAddressA_i(lsWbAddressA_i), .lsWbAddressB_i(lsWbAddressB_i),
    .lsOpCodeA_i(lsOpCodeA_i), .lsOpCodeB_i(lsOpCodeB_i),
    .lsPoperandA_i(lsPoperandA_i), .lsPoperandB_i(lsPoperandB_i),
    .lsSoperandA_i(lsSoperandA_i), .lsSoperandB_i(lsSoperandB_i),
    .memAck_i(memAck_i), .memRData_i(memRData_i),
    .memReq_o(memReq_o), .memWe_o(memWe_o), .memAddr_o(memAddr_o),
    .memWData_o(memWData_o), .stall_o(stall_o), .wbEnable_o(wbEnable_o),
    .wbAddress_o(wbAddress_o), .wbData_o(wbData_o), .lsError_o(lsError_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wb;
    logic [4:0]  wba;
    int          del;
    logic [15:0] rd;
  } req_t;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_req"},   32'(memReq_o), 32'd0);
    check_val({tag, "_we"},    32'(memWe_o), 32'd0);
    check_val({tag, "_addr"},  32'(memAddr_o), 32'd0);
    check_val({tag, "_wdata"}, 32'(memWData_o), 32'd0);
    check_val({tag, "_stall"}, 32'(stall_o), 32'd0);
    check_val({tag, "_wben"},  32'(wbEnable_o), 32'd0);
    check_val({tag, "_wba"},   32'(wbAddress_o), 32'd0);
    check_val({tag, "_wbd"},   32'(wbData_o), 32'd0);
    check_val({tag, "_err"},   32'(lsError_o), 32'd0);
  endtask

  // Lane inputs must already be driven; called at a negedge with the unit idle.
  // del_x: ack delay in cycles after the request appears, or TMO_DEL for no ack.
  task automatic do_bundle(input int del_a, input int del_b,
                           input logic [15:0] rd_a, input logic [15:0] rd_b);
    req_t q[$];
    req_t r;
    logic err_exp;
    int   stall_cnt;
    int   stall_exp;
    err_exp = 1'b0;
    if (lsEnableA_i) begin
      if (lsOpCodeA_i == LOAD_OP || lsOpCodeA_i == STORE_OP) begin
        r.we = (lsOpCodeA_i == STORE_OP); r.addr = lsPoperandA_i;
        r.wdata = r.we ? lsSoperandA_i : 16'h0; r.wb = !r.we && isWbLSA_i;
        r.wba = lsWbAddressA_i; r.del = del_a; r.rd = rd_a;
        q.push_back(r);
      end else err_exp = 1'b1;
    end
    if (lsEnableB_i) begin
      if (lsOpCodeB_i == LOAD_OP || lsOpCodeB_i == STORE_OP) begin
        r.we = (lsOpCodeB_i == STORE_OP); r.addr = lsPoperandB_i;
        r.wdata = r.we ? lsSoperandB_i : 16'h0; r.wb = !r.we && isWbLSB_i;
        r.wba = lsWbAddressB_i; r.del = del_b; r.rd = rd_b;
        q.push_back(r);
      end else err_exp = 1'b1;
    end
    stall_exp = 0;
    foreach (q[i]) stall_exp += (q[i].del == TMO_DEL) ? TIMEOUT : q[i].del + 1;

    step();
    lsEnableA_i = 1'b0;
    lsEnableB_i = 1'b0;
    stall_cnt = 0;
    check_val("err_capture", 32'(lsError_o), 32'(err_exp));
    while (q.size() > 0) begin
      r = q.pop_front();
      check_val("req", 32'(memReq_o), 32'd1);
      check_val("we", 32'(memWe_o), 32'(r.we));
      check_val("addr", 32'(memAddr_o), 32'(r.addr));
      check_val("wdata", 32'(memWData_o), 32'(r.wdata));
      if (r.del == TMO_DEL) begin
        for (int k = 1; k < TIMEOUT; k++) begin
          if (stall_o) stall_cnt++;
          step();
          check_val("tmo_req", 32'(memReq_o), 32'd1);
          check_val("tmo_err_early", 32'(lsError_o), 32'd0);
        end
        if (stall_o) stall_cnt++;
        step();
        check_val("tmo_err", 32'(lsError_o), 32'd1);
        check_val("tmo_wb", 32'(wbEnable_o), 32'd0);
      end else begin
        for (int k = 0; k < r.del; k++) begin
          if (stall_o) stall_cnt++;
          step();
          check_val("hold_req", 32'(memReq_o), 32'd1);
          check_val("hold_addr", 32'(memAddr_o), 32'(r.addr));
        end
        memAck_i = 1'b1;
        memRData_i = r.rd;
        if (stall_o) stall_cnt++;
        step();
        memAck_i = 1'b0;
        memRData_i = 16'($urandom);
        check_val("wb_en", 32'(wbEnable_o), 32'(r.wb));
        if (r.wb) begin
          check_val("wb_addr", 32'(wbAddress_o), 32'(r.wba));
          check_val("wb_data", 32'(wbData_o), 32'(r.rd));
        end
        check_val("ack_err", 32'(lsError_o), 32'd0);
      end
    end
    check_val("end_req", 32'(memReq_o), 32'd0);
    check_val("end_stall", 32'(stall_o), 32'd0);
    check_val("stall_cycles", 32'(stall_cnt), 32'(stall_exp));
    step();
    check_val("wb_once", 32'(wbEnable_o), 32'd0);
    check_val("err_once", 32'(lsError_o), 32'd0);
  endtask

  function automatic logic [6:0] pick_op();
    case ($urandom_range(0, 3))
      0: return LOAD_OP;
      1: return STORE_OP;
      2: return 7'($urandom);
      default: return LOAD_OP;
    endcase
  endfunction

  function automatic int pick_del();
    return ($urandom_range(0, 15) == 0) ? TMO_DEL : int'($urandom_range(0, 3));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    @(negedge clock_i);
    step();
    check_all_zero("reset");
    reset_i = 1'b0;
    step();

    // Single load with write-back
    lsEnableA_i = 1'b1; lsOpCodeA_i = LOAD_OP; lsPoperandA_i = 16'h0040;
    isWbLSA_i = 1'b1; lsWbAddressA_i = 5'd5; lsEnableB_i = 1'b0;
    do_bundle(0, 0, 16'hBEEF, 16'h0);

    // Dual: store then load to r7, each acked after 2 cycles
    lsEnableA_i = 1'b1; lsOpCodeA_i = STORE_OP; lsPoperandA_i = 16'h0010;
    lsSoperandA_i = 16'h1234; isWbLSA_i = 1'b0;
    lsEnableB_i = 1'b1; lsOpCodeB_i = LOAD_OP; lsPoperandB_i = 16'h0010;
    isWbLSB_i = 1'b1; lsWbAddressB_i = 5'd7;
    do_bundle(1, 1, 16'h0, 16'h1234);

    // Illegal opcode on A, B disabled
    lsEnableA_i = 1'b1; lsOpCodeA_i = 7'h05; lsEnableB_i = 1'b0;
    do_bundle(0, 0, 16'h0, 16'h0);

    // Both lanes illegal: a single error pulse
    lsEnableA_i = 1'b1; lsOpCodeA_i = 7'h05;
    lsEnableB_i = 1'b1; lsOpCodeB_i = 7'h7F;
    do_bundle(0, 0, 16'h0, 16'h0);

    // Timeout on an unacknowledged load
    lsEnableA_i = 1'b1; lsOpCodeA_i = LOAD_OP; lsPoperandA_i = 16'h0100;
    isWbLSA_i = 1'b1; lsWbAddressA_i = 5'd9; lsEnableB_i = 1'b0;
    do_bundle(TMO_DEL, 0, 16'h0, 16'h0);

    // Flush during A's request with B pending, ack on the flush edge
    lsEnableA_i = 1'b1; lsOpCodeA_i = LOAD_OP; lsPoperandA_i = 16'h0200;
    isWbLSA_i = 1'b1; lsWbAddressA_i = 5'd3;
    lsEnableB_i = 1'b1; lsOpCodeB_i = LOAD_OP; lsPoperandB_i = 16'h0204;
    isWbLSB_i = 1'b1; lsWbAddressB_i = 5'd4;
    step();
    lsEnableA_i = 1'b0; lsEnableB_i = 1'b0;
    check_val("flush_pre_req", 32'(memReq_o), 32'd1);
    flushBack_i = 1'b1; memAck_i = 1'b1; memRData_i = 16'hCAFE;
    step();
    flushBack_i = 1'b0; memAck_i = 1'b0;
    check_val("flush_req", 32'(memReq_o), 32'd0);
    check_val("flush_stall", 32'(stall_o), 32'd0);
    check_val("flush_wb", 32'(wbEnable_o), 32'd0);
    check_val("flush_err", 32'(lsError_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("flush_no_b_req", 32'(memReq_o), 32'd0);
      check_val("flush_no_wb", 32'(wbEnable_o), 32'd0);
    end

    // Reset in the middle of a dual operation
    lsEnableA_i = 1'b1; lsOpCodeA_i = STORE_OP; lsPoperandA_i = 16'h0300;
    lsSoperandA_i = 16'h5A5A;
    lsEnableB_i = 1'b1; lsOpCodeB_i = LOAD_OP; lsPoperandB_i = 16'h0302;
    isWbLSB_i = 1'b1; lsWbAddressB_i = 5'd11;
    step();
    lsEnableA_i = 1'b0; lsEnableB_i = 1'b0;
    memAck_i = 1'b1; memRData_i = 16'h0;
    step();
    memAck_i = 1'b0;
    check_val("pre_reset_b_req", 32'(memReq_o), 32'd1);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check_all_zero("midreset");
    lsEnableA_i = 1'b1; lsOpCodeA_i = LOAD_OP; lsPoperandA_i = 16'h0400;
    isWbLSA_i = 1'b1; lsWbAddressA_i = 5'd12; lsEnableB_i = 1'b0;
    do_bundle(2, 0, 16'h7777, 16'h0);

    // Randomized bundles
    for (int i = 0; i < 60; i++) begin
      lsEnableA_i    = 1'($urandom);
      lsEnableB_i    = 1'($urandom);
      lsOpCodeA_i    = pick_op();
      lsOpCodeB_i    = pick_op();
      isWbLSA_i      = 1'($urandom);
      isWbLSB_i      = 1'($urandom);
      lsWbAddressA_i = 5'($urandom);
      lsWbAddressB_i = 5'($urandom);
      lsPoperandA_i  = 16'($urandom);
      lsPoperandB_i  = 16'($urandom);
      lsSoperandA_i  = 16'($urandom);
      lsSoperandB_i  = 16'($urandom);
      do_bundle(pick_del(), pick_del(), 16'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
